// File: rtl/float13_pkg.sv
// Shared definitions for the 13-bit float format (sign, 4-bit exponent, 8-bit significand)
// and the frame-max reduction state encoding.
package float13_pkg;

    localparam int unsigned FLOAT_W  = 13;
    localparam int unsigned SIGN_BIT = 12;
    localparam int unsigned EXP_MSB  = 11;
    localparam int unsigned EXP_LSB  = 8;
    localparam int unsigned SIG_MSB  = 7;
    localparam int unsigned SIG_LSB  = 0;

    typedef enum logic {
        StAccum = 1'b0,
        StHold  = 1'b1
    } frame_state_e;

endpackage

// File: rtl/floating_greater.sv
// Strict greater-than for sign-magnitude 13-bit floats; +0 and -0 compare equal.
module floating_greater
    import float13_pkg::*;
(
    input  logic [FLOAT_W-1:0] a,
    input  logic [FLOAT_W-1:0] b,
    output logic               gt
);

    logic                a_neg;
    logic                b_neg;
    logic [SIGN_BIT-1:0] a_mag;
    logic [SIGN_BIT-1:0] b_mag;

    // Exponent sits above the significand, so the magnitude orders as a plain unsigned value.
    assign a_neg = a[SIGN_BIT];
    assign b_neg = b[SIGN_BIT];
    assign a_mag = a[EXP_MSB:SIG_LSB];
    assign b_mag = b[EXP_MSB:SIG_LSB];

    always_comb begin
        gt = 1'b0;
        if ((a_mag == '0) && (b_mag == '0)) begin
            gt = 1'b0;
        end else if (a_neg != b_neg) begin
            gt = !a_neg;
        end else if (!a_neg) begin
            gt = a_mag > b_mag;
        end else begin
            gt = a_mag < b_mag;
        end
    end

endmodule

// File: rtl/float_frame_max.sv
// Framed running-maximum reduction over a valid/ready stream of 13-bit floats; reports the
// peak value, its position, the frame length and whether the length limit closed the frame.
module float_frame_max
    import float13_pkg::*;
#(
    parameter int unsigned IDX_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FLOAT_W-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FLOAT_W-1:0] out_max,
    output logic [IDX_W-1:0]   out_idx,
    output logic [IDX_W:0]     out_count,
    output logic               out_trunc
);

    frame_state_e       state_q, state_d;
    logic               first_q, first_d;
    logic [FLOAT_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W:0]     count_q, count_d;
    logic               trunc_q, trunc_d;

    logic               accept;
    logic               gt;
    logic [IDX_W-1:0]   pos;
    logic               at_limit;

    floating_greater u_cmp (
        .a  (in_data),
        .b  (max_q),
        .gt (gt)
    );

    assign in_ready  = reset_n && (state_q == StAccum);
    assign accept    = in_valid && in_ready;
    // Position of the current sample; count_q never exceeds 2^IDX_W-1 while still accumulating.
    assign pos       = first_q ? '0 : count_q[IDX_W-1:0];
    assign at_limit  = (pos == {IDX_W{1'b1}});

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        max_d   = max_q;
        idx_d   = idx_q;
        count_d = count_q;
        trunc_d = trunc_q;
        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    first_d = 1'b0;
                    count_d = first_q ? {{IDX_W{1'b0}}, 1'b1} : count_q + {{IDX_W{1'b0}}, 1'b1};
                    if (first_q || gt) begin
                        max_d = in_data;
                        idx_d = pos;
                    end
                    trunc_d = at_limit && !in_last;
                    if (in_last || at_limit) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StAccum;
                    first_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StAccum;
            first_q <= 1'b1;
            max_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            trunc_q <= trunc_d;
        end
    end

    assign out_valid = (state_q == StHold);
    assign out_max   = max_q;
    assign out_idx   = idx_q;
    assign out_count = count_q;
    assign out_trunc = trunc_q;

endmodule

// File: tb/tb_float_frame_max.sv
// Directed bench for float_frame_max: one default-width instance and one with IDX_W=2
// for the length-limit case.
module tb_float_frame_max;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_trunc;
    logic [12:0] a_in_data, a_out_max;
    logic [7:0]  a_out_idx;
    logic [8:0]  a_out_count;

    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_trunc;
    logic [12:0] b_in_data, b_out_max;
    logic [1:0]  b_out_idx;
    logic [2:0]  b_out_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    float_frame_max #(.IDX_W(8)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_last   (a_in_last),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_max   (a_out_max),
        .out_idx   (a_out_idx),
        .out_count (a_out_count),
        .out_trunc (a_out_trunc)
    );

    float_frame_max #(.IDX_W(2)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_last   (b_in_last),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_max   (b_out_max),
        .out_idx   (b_out_idx),
        .out_count (b_out_count),
        .out_trunc (b_out_trunc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample to instance a (sel=0) or b (sel=1) until it is accepted.
    task automatic push(input bit sel, input logic [12:0] d, input logic l);
        int waited;
        waited = 0;
        while (((sel ? b_in_ready : a_in_ready) !== 1'b1) && (waited < 20)) begin
            tick();
            waited++;
        end
        if (waited >= 20) begin
            n_assert++;
            n_fail++;
            $error("FAIL push_timeout: observed in_ready 0 expected 1");
        end
        if (sel) begin
            b_in_valid = 1'b1; b_in_data = d; b_in_last = l;
        end else begin
            a_in_valid = 1'b1; a_in_data = d; a_in_last = l;
        end
        tick();
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        a_in_last  = 1'b0;
        b_in_last  = 1'b0;
    endtask

    task automatic check_a(input string tag, input logic [12:0] mx, input logic [7:0] idx,
                           input logic [8:0] cnt, input logic tr);
        check({tag, "_valid"}, 32'(a_out_valid), 32'd1);
        check({tag, "_ready"}, 32'(a_in_ready),  32'd0);
        check({tag, "_max"},   32'(a_out_max),   32'(mx));
        check({tag, "_idx"},   32'(a_out_idx),   32'(idx));
        check({tag, "_count"}, 32'(a_out_count), 32'(cnt));
        check({tag, "_trunc"}, 32'(a_out_trunc), 32'(tr));
    endtask

    task automatic consume_a();
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        a_in_valid  = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_out_ready = 1'b0;
        b_in_valid  = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b0;
        tick();
        tick();

        check("rst_valid", 32'(a_out_valid), 32'd0);
        check("rst_ready", 32'(a_in_ready),  32'd0);
        check("rst_max",   32'(a_out_max),   32'd0);
        check("rst_idx",   32'(a_out_idx),   32'd0);
        check("rst_count", 32'(a_out_count), 32'd0);
        check("rst_trunc", 32'(a_out_trunc), 32'd0);
        reset_n = 1'b1;
        #1;
        check("rst_release_ready", 32'(a_in_ready), 32'd1);

        // Positive frame: peak in the middle.
        push(1'b0, 13'h0580, 1'b0);
        push(1'b0, 13'h0690, 1'b0);
        push(1'b0, 13'h0600, 1'b0);
        check("f1_not_yet_valid", 32'(a_out_valid), 32'd0);
        push(1'b0, 13'h0400, 1'b1);
        check_a("f1", 13'h0690, 8'd1, 9'd4, 1'b0);
        consume_a();
        check("f1_back_ready", 32'(a_in_ready),  32'd1);
        check("f1_drop_valid", 32'(a_out_valid), 32'd0);
        check("f1_max_held",   32'(a_out_max),   32'h0690);

        // All-negative frame.
        push(1'b0, 13'h1690, 1'b0);
        push(1'b0, 13'h1480, 1'b1);
        check_a("f2", 13'h1480, 8'd1, 9'd2, 1'b0);
        consume_a();

        // Signed zeros tie; earliest wins.
        push(1'b0, 13'h1000, 1'b0);
        push(1'b0, 13'h0000, 1'b0);
        push(1'b0, 13'h0000, 1'b1);
        check_a("f3", 13'h1000, 8'd0, 9'd3, 1'b0);
        consume_a();

        // Single-sample frame with a stalled consumer.
        push(1'b0, 13'h0A12, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_a($sformatf("stall%0d", i), 13'h0A12, 8'd0, 9'd1, 1'b0);
            tick();
        end
        a_out_ready = 1'b1;
        check_a("stall_last", 13'h0A12, 8'd0, 9'd1, 1'b0);
        tick();
        a_out_ready = 1'b0;
        check("stall_release_ready", 32'(a_in_ready),  32'd1);
        check("stall_release_valid", 32'(a_out_valid), 32'd0);

        // Length limit on the IDX_W=2 instance.
        push(1'b1, 13'h0100, 1'b0);
        push(1'b1, 13'h0300, 1'b0);
        push(1'b1, 13'h0200, 1'b0);
        check("b_not_yet_valid", 32'(b_out_valid), 32'd0);
        push(1'b1, 13'h0100, 1'b0);
        check("b_valid", 32'(b_out_valid), 32'd1);
        check("b_ready", 32'(b_in_ready),  32'd0);
        check("b_max",   32'(b_out_max),   32'h0300);
        check("b_idx",   32'(b_out_idx),   32'd1);
        check("b_count", 32'(b_out_count), 32'd4);
        check("b_trunc", 32'(b_out_trunc), 32'd1);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        push(1'b1, 13'h0700, 1'b1);
        check("b2_valid", 32'(b_out_valid), 32'd1);
        check("b2_max",   32'(b_out_max),   32'h0700);
        check("b2_idx",   32'(b_out_idx),   32'd0);
        check("b2_count", 32'(b_out_count), 32'd1);
        check("b2_trunc", 32'(b_out_trunc), 32'd0);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;

        // Reset mid-frame discards the partial frame.
        push(1'b0, 13'h0500, 1'b0);
        push(1'b0, 13'h0600, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mrst_ready_comb", 32'(a_in_ready), 32'd0);
        tick();
        check("mrst_valid", 32'(a_out_valid), 32'd0);
        check("mrst_ready", 32'(a_in_ready),  32'd0);
        check("mrst_count", 32'(a_out_count), 32'd0);
        reset_n = 1'b1;
        push(1'b0, 13'h0200, 1'b1);
        check_a("post_rst", 13'h0200, 8'd0, 9'd1, 1'b0);
        consume_a();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
